// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - opcode/funct constants and FSM encoding for the HI/LO unit
package muldiv_pkg;

  localparam logic [5:0] RTYPE = 6'h00;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_dec.sv
// rtl/muldiv_dec.sv - opcode/funct decode of the HI/LO instruction group
module muldiv_dec
  import muldiv_pkg::*;
(
  input  logic       valid,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_mf_hi,
  output logic       is_mf_lo,
  output logic       is_mt_hi,
  output logic       is_mt_lo,
  output logic       is_mul,
  output logic       is_div,
  output logic       is_signed
);

  always_comb begin
    is_mf_hi  = 1'b0;
    is_mf_lo  = 1'b0;
    is_mt_hi  = 1'b0;
    is_mt_lo  = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    if (valid && opcode == RTYPE) begin
      case (funct)
        MFHI:  is_mf_hi = 1'b1;
        MFLO:  is_mf_lo = 1'b1;
        MTHI:  is_mt_hi = 1'b1;
        MTLO:  is_mt_lo = 1'b1;
        MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
        MULTU: is_mul = 1'b1;
        DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
        DIVU:  is_div = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_result
);

  logic is_mf_hi, is_mf_lo, is_mt_hi, is_mt_lo, is_mul, is_div, is_signed;
  logic hilo_op, accept;
  state_t state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   q, b, a_raw;
  logic               neg_q, neg_r, op_div, div0;
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  muldiv_dec u_dec (
    .valid     (valid),
    .opcode    (opcode),
    .funct     (funct),
    .is_mf_hi  (is_mf_hi),
    .is_mf_lo  (is_mf_lo),
    .is_mt_hi  (is_mt_hi),
    .is_mt_lo  (is_mt_lo),
    .is_mul    (is_mul),
    .is_div    (is_div),
    .is_signed (is_signed)
  );

  assign hilo_op   = is_mf_hi | is_mf_lo | is_mt_hi | is_mt_lo | is_mul | is_div;
  assign stall     = valid & hilo_op & busy;
  assign accept    = (state == IDLE) & (is_mul | is_div);
  assign mf_result = is_mf_hi ? hi : (is_mf_lo ? lo : '0);

  // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
  assign a_sgn = is_signed & rs_data[WIDTH-1];
  assign b_sgn = is_signed & rt_data[WIDTH-1];
  assign a_mag = a_sgn ? -rs_data : rs_data;
  assign b_mag = b_sgn ? -rt_data : rt_data;

  assign mul_sum  = q[0] ? acc + {1'b0, b} : acc;
  assign div_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, b};
  assign div_diff = div_sh - {1'b0, b};

  assign prod     = {acc[WIDTH-1:0], q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -q : q;
  assign rem_fix  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state == RUN || state == FIX) busy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0; lo <= '0; done <= 1'b0; cnt <= '0;
      acc <= '0; q <= '0; b <= '0; a_raw <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; op_div <= 1'b0; div0 <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mt_hi) hi <= rs_data;
          if (is_mt_lo) lo <= rs_data;
          if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= a_mag;
            b      <= b_mag;
            a_raw  <= rs_data;
            neg_q  <= a_sgn ^ b_sgn;
            neg_r  <= a_sgn;
            op_div <= is_div;
            div0   <= (rt_data == '0);
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (op_div) begin
            acc <= div_ge ? div_diff : div_sh;
            q   <= {q[WIDTH-2:0], div_ge};
          end else begin
            acc <= {1'b0, mul_sum[WIDTH:1]};
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (!op_div) begin
            {hi, lo} <= prod_fix;
          end else if (div0) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
